// File: rtl/systolic_result_drain.sv
// Drains a W x W output-stationary tile from the systolic array into a row FIFO.
// Rows are then streamed out one element per handshake. Optional macro: SYSTOLIC_DRAIN_RELU_EN.
module systolic_result_drain #(
    parameter int SUM_WIDTH      = 16,
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int FIFO_ROWS      = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] sum_bus,
    input  logic                                start,
    output logic                                start_ready,
    output logic                                busy,
    output logic [SUM_WIDTH-1:0]                out_data,
    output logic [$clog2(SYSTOLIC_WIDTH)-1:0]   out_row,
    output logic [$clog2(SYSTOLIC_WIDTH)-1:0]   out_col,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int W     = SYSTOLIC_WIDTH;
    localparam int RW    = $clog2(W);
    localparam int PW    = $clog2(FIFO_ROWS);
    localparam int CW    = PW + 1;
    localparam int ROW_W = W * SUM_WIDTH;

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   cap_row, cap_row_nxt;
    logic            push, pop, accept, hs, space_ok;
    logic [RW-1:0]   push_row;

    logic [ROW_W-1:0] fifo_data [FIFO_ROWS];
    logic [RW-1:0]    fifo_row  [FIFO_ROWS];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    logic [CW-1:0]    occupancy;

    logic                 ser_full;
    logic [ROW_W-1:0]     ser_data;
    logic [RW-1:0]        ser_row;
    logic [RW-1:0]        ser_col;
    logic signed [SUM_WIDTH-1:0] elem;

`ifdef SYSTOLIC_DRAIN_RELU_EN
    function automatic logic [SUM_WIDTH-1:0] relu(input logic signed [SUM_WIDTH-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction
`endif

    // Admission control: a whole tile must fit before capture may begin.
    always_comb begin
        occupancy   = fifo_cnt + CW'(ser_full);
        space_ok    = (int'(occupancy) <= FIFO_ROWS - W);
        start_ready = rst_n && (state == IDLE) && !clear && space_ok;
        accept      = start && start_ready;
        busy        = (state == CAPTURE);
    end

    always_comb begin
        state_nxt   = state;
        cap_row_nxt = cap_row;
        push        = 1'b0;
        push_row    = cap_row;
        case (state)
            IDLE: begin
                if (accept) begin
                    push        = 1'b1;
                    push_row    = RW'(W - 1);
                    cap_row_nxt = RW'(W - 2);
                    state_nxt   = CAPTURE;
                end
            end
            CAPTURE: begin
                push = 1'b1;
                if (cap_row == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cap_row_nxt = cap_row - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt   = IDLE;
            cap_row_nxt = '0;
            push        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cap_row <= '0;
        end else begin
            state   <= state_nxt;
            cap_row <= cap_row_nxt;
        end
    end

    // Serializer reloads from the FIFO when empty or as its last column is taken.
    assign hs  = ser_full && out_ready;
    assign pop = !clear && (fifo_cnt != '0) &&
                 (!ser_full || (hs && ser_col == RW'(W - 1)));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= sum_bus;
            fifo_row[wr_ptr]  <= push_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_full <= 1'b0;
            ser_data <= '0;
            ser_row  <= '0;
            ser_col  <= '0;
        end else if (clear) begin
            ser_full <= 1'b0;
            ser_data <= '0;
            ser_row  <= '0;
            ser_col  <= '0;
        end else if (pop) begin
            ser_full <= 1'b1;
            ser_data <= fifo_data[rd_ptr];
            ser_row  <= fifo_row[rd_ptr];
            ser_col  <= '0;
        end else if (hs) begin
            if (ser_col == RW'(W - 1)) begin
                ser_full <= 1'b0;
            end else begin
                ser_col <= ser_col + 1'b1;
            end
        end
    end

    // Column k lives at the high end of the row vector for k=0.
    always_comb begin
        elem = '0;
        for (int k = 0; k < W; k++) begin
            if (ser_col == RW'(k)) begin
                elem = ser_data[(W-1-k)*SUM_WIDTH +: SUM_WIDTH];
            end
        end
    end

`ifdef SYSTOLIC_DRAIN_RELU_EN
    assign out_data = relu(elem);
`else
    assign out_data = elem;
`endif

    assign out_valid = ser_full;
    assign out_row   = ser_row;
    assign out_col   = ser_col;
    assign out_last  = ser_full && (ser_row == '0) && (ser_col == RW'(W - 1));

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed self-checking bench for systolic_result_drain (W=4, FIFO_ROWS=8).
module tb_systolic_result_drain;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [63:0] sum_bus;
    logic        start;
    logic        start_ready;
    logic        busy;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] got[$];
    logic        mon_stab  = 1'b0;
    logic        stall_prev = 1'b0;
    logic [20:0] prev_out  = '0;

    systolic_result_drain #(
        .SUM_WIDTH(16),
        .SYSTOLIC_WIDTH(4),
        .FIFO_ROWS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .sum_bus(sum_bus),
        .start(start),
        .start_ready(start_ready),
        .busy(busy),
        .out_data(out_data),
        .out_row(out_row),
        .out_col(out_col),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] row_vec(input int r);
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[(3-k)*16 +: 16] = 16'(r*256 + k);
        return v;
    endfunction

    function automatic logic [31:0] exp_elem(input int i);
        int r;
        int c;
        r = 3 - i / 4;
        c = i % 4;
        return {11'b0, (i == 15), 2'(r), 2'(c), 16'(r*256 + c)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Handshake collector and stall-stability monitor
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (out_valid && out_ready)
                got.push_back({11'b0, out_last, out_row, out_col, out_data});
            if (mon_stab && stall_prev)
                check("stall_hold", {11'b0, out_valid, out_row, out_col, out_data},
                      {11'b0, prev_out});
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_row, out_col, out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // mode 0: consumer always ready; mode 1: toggled ready then a 5-cycle stall
    task automatic drive_tile(input int mode);
        got.delete();
        mon_stab = (mode == 1);
        for (int i = 0; i < 40; i++) begin
            start   = (i == 0);
            sum_bus = (i < 4) ? row_vec(3 - i) : 64'h0;
            if (mode == 0)      out_ready = 1'b1;
            else if (i < 8)     out_ready = (i % 2 == 0);
            else if (i < 13)    out_ready = 1'b0;
            else                out_ready = 1'b1;
            @(negedge clk);
            if (i == 0) check("tile_start_ready", 32'(start_ready), 32'd1);
            if (i < 2)  check("tile_latency_idle", 32'(out_valid), 32'd0);
            if (i == 1) check("tile_busy", 32'(busy), 32'd1);
            if (i == 2) begin
                check("tile_first_valid", 32'(out_valid), 32'd1);
                check("tile_first_data", 32'(out_data), 32'h0300);
            end
            next_cycle();
        end
        mon_stab = 1'b0;
        check("tile_count", got.size(), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check($sformatf("tile_elem%0d", i), got[i], exp_elem(i));
    endtask

    task automatic occupancy_test();
        int hs;
        logic accepted;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start   = (i == 0) || (i == 4);
            sum_bus = row_vec(3 - (i % 4));
            @(negedge clk);
            if (i == 0) check("occ_tile1_ready", 32'(start_ready), 32'd1);
            if (i == 4) check("occ_tile2_ready", 32'(start_ready), 32'd1);
            next_cycle();
        end
        start   = 1'b1;
        sum_bus = 64'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("occ_full_blocked", 32'(start_ready), 32'd0);
            next_cycle();
        end
        out_ready = 1'b1;
        hs        = 0;
        accepted  = 1'b0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge clk);
            check($sformatf("occ_ready_hs%0d", hs), 32'(start_ready), 32'(hs >= 16));
            if (start_ready) accepted = 1'b1;
            if (out_valid && out_ready) hs++;
            next_cycle();
        end
        if (!accepted) check("occ_third_accept_timeout", 32'd0, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("occ_third_busy", 32'(busy), 32'd1);
        next_cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        start     = 1'b0;
        sum_bus   = 64'h0;
        out_ready = 1'b0;

        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_start_ready", 32'(start_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_last", 32'(out_last), 32'd0);
        check("idle_out_data", 32'(out_data), 32'd0);
        next_cycle();

        drive_tile(0);
        drive_tile(1);

        occupancy_test();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        next_cycle();

        // clear during capture cycle 2
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start   = (i == 0);
            clear   = (i == 2);
            sum_bus = row_vec(3);
            @(negedge clk);
            if (i == 2) check("clr_start_ready_low", 32'(start_ready), 32'd0);
            if (i == 3) begin
                check("clr_valid_dropped", 32'(out_valid), 32'd0);
                check("clr_busy", 32'(busy), 32'd0);
                check("clr_data_zero", 32'(out_data), 32'd0);
                check("clr_start_ready", 32'(start_ready), 32'd1);
            end
            if (i == 5) check("clr_nothing_left", 32'(out_valid), 32'd0);
            next_cycle();
        end

        // sign handling of the emitted element
        got.delete();
        for (int i = 0; i < 25; i++) begin
            start   = (i == 0);
            sum_bus = (i == 0) ? {16'h8001, 16'h7FFF, 16'h0000, 16'h0000} : 64'h0;
            @(negedge clk);
            next_cycle();
        end
        check("relu_count", got.size(), 32'd16);
        if (got.size() >= 2) begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
            check("relu_neg", 32'(got[0][15:0]), 32'h0000);
`else
            check("relu_neg", 32'(got[0][15:0]), 32'h8001);
`endif
            check("relu_pos", 32'(got[1][15:0]), 32'h7FFF);
        end

        // asynchronous reset in the middle of a stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start   = (i == 0);
            sum_bus = row_vec(2);
            @(negedge clk);
            next_cycle();
        end
        start = 1'b0;
        @(negedge clk);
        check("async_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid_low", 32'(out_valid), 32'd0);
        check("async_busy_low", 32'(busy), 32'd0);
        check("async_start_ready_low", 32'(start_ready), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
